lambda_argmax: RTL and testbench

- Consumes the per-sample timing metric lambda = |gamma| - rho*phi, produced as signed Q6.8 by the metric subtraction stage.
- Searches each window of WIN_LEN valid samples for the maximum, which is the ML timing offset theta.
- Also captures the gamma angle sample aligned with that maximum, for the downstream CFO stage.
- Presents {theta, lambda_max, angle} through a valid/ready holding register.

---
 rtl/lambda_argmax_pkg.sv | 28 ++
 rtl/argmax_out_buf.sv | 50 +++++
 rtl/lambda_argmax.sv | 126 ++++++++++++
 tb/tb_lambda_argmax.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lambda_argmax_pkg.sv
// Shared types for the timing-metric argmax stage: metric/angle widths,
// the signed sample types and the search FSM encoding.
package lambda_argmax_pkg;

  localparam int LAMBDA_W        = 14;  // signed Q6.8 metric
  localparam int ANG_W           = 12;  // signed gamma angle
  localparam int WIN_LEN_DEFAULT = 80;  // N + L with N=64, CP=16

  typedef logic signed [LAMBDA_W-1:0] lambda_t;
  typedef logic signed [ANG_W-1:0]    ang_t;

  // Metric and the angle that travels with it.
  typedef struct packed {
    lambda_t val;
    ang_t    ang;
  } sample_t;

  typedef enum logic {
    ST_IDLE,
    ST_SEARCH
  } state_t;

  // Strictly greater, so that equal metrics keep the earliest index.
  function automatic logic beats(input lambda_t cand, input lambda_t best);
    return cand > best;
  endfunction

endpackage

// File: rtl/argmax_out_buf.sv
// Valid/ready holding register for the argmax result. A new result always
// wins; overwriting an unconsumed result raises a sticky overrun flag.
module argmax_out_buf
  import lambda_argmax_pkg::*;
#(
  parameter int IDX_W = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  input  lambda_t          load_val,
  input  ang_t             load_ang,
  input  logic             ready,
  output logic             valid,
  output logic [IDX_W-1:0] idx,
  output lambda_t          val,
  output ang_t             ang,
  output logic             overrun
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      valid   <= 1'b0;
      overrun <= 1'b0;
      idx     <= '0;
      val     <= '0;
      ang     <= '0;
    end else if (clear) begin
      // Dropping the held result also zeroes the data it carried.
      valid   <= 1'b0;
      overrun <= 1'b0;
      idx     <= '0;
      val     <= '0;
      ang     <= '0;
    end else if (load) begin
      idx   <= load_idx;
      val   <= load_val;
      ang   <= load_ang;
      valid <= 1'b1;
      if (valid && !ready) begin
        overrun <= 1'b1;
      end
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/lambda_argmax.sv
// Windowed argmax over the timing metric lambda: finds theta (index of the
// maximum) and the gamma angle aligned with it, then hands them downstream.
module lambda_argmax
  import lambda_argmax_pkg::*;
#(
  parameter int WIN_LEN = WIN_LEN_DEFAULT,
  parameter int IDX_W   = $clog2(WIN_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync_clear,
  input  logic             lambda_valid,
  input  lambda_t          lambda_in,
  input  ang_t             ang_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] theta_idx,
  output lambda_t          lambda_max,
  output ang_t             ang_at_max,
  output logic             overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIN_LEN - 1);

  state_t           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  sample_t          best_q, best_d;
  logic [IDX_W-1:0] best_idx_q, best_idx_d;

  // Post-compare candidate: the running best after considering lambda_in.
  sample_t          cand;
  logic [IDX_W-1:0] cand_idx;
  logic             res_load;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    best_d     = best_q;
    best_idx_d = best_idx_q;
    res_load   = 1'b0;
    cand       = best_q;
    cand_idx   = best_idx_q;

    if (beats(lambda_in, best_q.val)) begin
      cand     = '{val: lambda_in, ang: ang_in};
      cand_idx = cnt_q;
    end

    if (sync_clear) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          // First sample of a window loads without any comparison.
          if (en && lambda_valid) begin
            best_d     = '{val: lambda_in, ang: ang_in};
            best_idx_d = '0;
            cnt_d      = IDX_W'(1);
            state_d    = ST_SEARCH;
          end
        end
        ST_SEARCH: begin
          if (!en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (lambda_valid) begin
            best_d     = cand;
            best_idx_d = cand_idx;
            if (cnt_q == LAST_IDX) begin
              res_load = 1'b1;
              cnt_d    = '0;
              state_d  = ST_IDLE;
            end else begin
              cnt_d = cnt_q + IDX_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst) begin
      // NOTE: these are a handful of flops, not a memory, so resetting them
      // is cheap and gives deterministic results after reset.
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      best_q     <= '0;
      best_idx_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      best_q     <= best_d;
      best_idx_q <= best_idx_d;
    end
  end

  argmax_out_buf #(
    .IDX_W(IDX_W)
  ) u_out_buf (
    .clk      (clk),
    .rst      (rst),
    .clear    (sync_clear),
    .load     (res_load),
    .load_idx (cand_idx),
    .load_val (cand.val),
    .load_ang (cand.ang),
    .ready    (out_ready),
    .valid    (out_valid),
    .idx      (theta_idx),
    .val      (lambda_max),
    .ang      (ang_at_max),
    .overrun  (overrun)
  );

endmodule

// File: tb/tb_lambda_argmax.sv
// Self-checking bench for lambda_argmax (WIN_LEN=8): directed scenarios plus
// a randomized run, all compared against a queue-based window model.
module tb_lambda_argmax;
  import lambda_argmax_pkg::*;

  localparam int WL = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       sync_clear = 1'b0;
  logic       lambda_valid = 1'b0;
  logic       out_ready = 1'b0;
  lambda_t    lambda_in = '0;
  ang_t       ang_in = '0;
  logic       out_valid;
  logic       overrun;
  logic [2:0] theta_idx;
  lambda_t    lambda_max;
  ang_t       ang_at_max;

  always #5 clk = ~clk;

  lambda_argmax #(
    .WIN_LEN(WL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .sync_clear   (sync_clear),
    .lambda_valid (lambda_valid),
    .lambda_in    (lambda_in),
    .ang_in       (ang_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .theta_idx    (theta_idx),
    .lambda_max   (lambda_max),
    .ang_at_max   (ang_at_max),
    .overrun      (overrun)
  );

  int    n_checks = 0;
  int    n_pass = 0;
  int    n_fail = 0;
  string phase = "init";

  // Reference model: the samples of the open window plus the held result.
  int q_lam[$];
  int q_ang[$];
  bit m_valid = 1'b0;
  bit m_ovr = 1'b0;
  int m_idx = 0;
  int m_val = 0;
  int m_ang = 0;

  int wa[WL] = '{-5, 3, 7, 2, 7, -1, 0, 4};
  int wb[WL] = '{-100, -3, -50, -3, -9, -200, -7, -8};

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s.%s: observed %0d expected %0d", phase, tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q_lam.delete();
    q_ang.delete();
    m_valid = 1'b0;
    m_ovr   = 1'b0;
    m_idx   = 0;
    m_val   = 0;
    m_ang   = 0;
  endtask

  // Applies one clock edge worth of inputs to the model.
  task automatic model_edge();
    bit deliver;
    int bi;
    deliver = 1'b0;
    bi      = 0;
    if (!rst || sync_clear) begin
      model_clear();
      return;
    end
    if (!en) begin
      q_lam.delete();
      q_ang.delete();
    end else if (lambda_valid) begin
      q_lam.push_back(int'(lambda_in));
      q_ang.push_back(int'(ang_in));
      if (q_lam.size() == WL) begin
        for (int i = 1; i < WL; i++) begin
          if (q_lam[i] > q_lam[bi]) bi = i;
        end
        deliver = 1'b1;
      end
    end
    if (deliver) begin
      if (m_valid && !out_ready) m_ovr = 1'b1;
      m_valid = 1'b1;
      m_idx   = bi;
      m_val   = q_lam[bi];
      m_ang   = q_ang[bi];
      q_lam.delete();
      q_ang.delete();
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("overrun", 32'(overrun), 32'(m_ovr));
    check("theta_idx", 32'(theta_idx), m_idx);
    check("lambda_max", 32'(lambda_max), m_val);
    check("ang_at_max", 32'(ang_at_max), m_ang);
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input int lam, input int ang);
    en           = 1'b1;
    lambda_valid = 1'b1;
    lambda_in    = lambda_t'(lam);
    ang_in       = ang_t'(ang);
    tick();
    lambda_valid = 1'b0;
  endtask

  function automatic int ang_of(input int i);
    return 37 * i - 100;
  endfunction

  task automatic send_rand();
    lambda_t l;
    ang_t    a;
    l = ($urandom_range(0, 1) == 0) ? lambda_t'($urandom)
                                    : lambda_t'($urandom_range(0, 6)) - lambda_t'(3);
    a = ang_t'($urandom);
    send(int'(l), int'(a));
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    phase = "reset";
    idle(2);
    rst = 1'b1;
    idle(1);

    phase = "win_a";
    for (int i = 0; i < WL - 1; i++) send(wa[i], ang_of(i));
    check("early_valid", 32'(out_valid), 0);
    send(wa[WL-1], ang_of(WL - 1));
    check("a_valid", 32'(out_valid), 1);
    check("a_theta", 32'(theta_idx), 2);
    check("a_max", 32'(lambda_max), 7);
    check("a_ang", 32'(ang_at_max), ang_of(2));
    accept();
    check("a_accepted", 32'(out_valid), 0);

    phase = "win_b";
    for (int i = 0; i < WL; i++) send(wb[i], ang_of(i));
    check("b_theta", 32'(theta_idx), 1);
    check("b_max", 32'(lambda_max), -3);
    accept();

    phase = "win_a_gaps";
    for (int i = 0; i < WL; i++) begin
      send(wa[i], ang_of(i));
      idle(1 + $urandom_range(0, 2));
    end
    check("g_theta", 32'(theta_idx), 2);
    check("g_max", 32'(lambda_max), 7);
    check("g_ang", 32'(ang_at_max), ang_of(2));
    accept();

    phase = "overrun";
    repeat (2 * WL) send_rand();
    check("ovr_set", 32'(overrun), 1);
    accept();
    check("ovr_drained", 32'(out_valid), 0);
    check("ovr_sticky", 32'(overrun), 1);
    idle(3);
    check("ovr_still", 32'(overrun), 1);
    sync_clear = 1'b1;
    tick();
    sync_clear = 1'b0;
    check("ovr_cleared", 32'(overrun), 0);

    phase = "en_abort";
    for (int i = 0; i < 5; i++) send(wb[i], ang_of(i));
    en           = 1'b0;
    lambda_valid = 1'b1;
    tick();
    lambda_valid = 1'b0;
    idle(2);
    check("abort_no_result", 32'(out_valid), 0);
    for (int i = 0; i < WL; i++) send(wa[i], ang_of(i));
    check("abort_theta", 32'(theta_idx), 2);
    check("abort_valid", 32'(out_valid), 1);

    phase = "rst_mid";
    for (int i = 0; i < 4; i++) send(wb[i], ang_of(i));
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("rst_valid", 32'(out_valid), 0);
    check("rst_theta", 32'(theta_idx), 0);
    check("rst_max", 32'(lambda_max), 0);
    for (int i = 0; i < WL; i++) send(wa[i], ang_of(i));
    check("rst_next_theta", 32'(theta_idx), 2);

    phase = "sync_mid";
    for (int i = 0; i < WL; i++) send(wb[i], ang_of(i));
    check("sync_pre_ovr", 32'(overrun), 1);
    for (int i = 0; i < 6; i++) send(wa[i], ang_of(i));
    sync_clear   = 1'b1;
    lambda_valid = 1'b1;
    lambda_in    = lambda_t'(100);
    tick();
    sync_clear   = 1'b0;
    lambda_valid = 1'b0;
    check("sync_valid", 32'(out_valid), 0);
    check("sync_ovr", 32'(overrun), 0);
    for (int i = 0; i < WL; i++) send(wb[i], ang_of(i));
    check("sync_next_theta", 32'(theta_idx), 1);
    check("sync_next_max", 32'(lambda_max), -3);
    accept();

    phase = "random";
    repeat (600) begin
      en           = ($urandom_range(0, 29) != 0);
      lambda_valid = ($urandom_range(0, 2) != 0);
      lambda_in    = ($urandom_range(0, 1) == 0) ? lambda_t'($urandom)
                                                 : lambda_t'($urandom_range(0, 4));
      ang_in       = ang_t'($urandom);
      out_ready    = ($urandom_range(0, 1) == 1);
      sync_clear   = ($urandom_range(0, 149) == 0);
      tick();
    end
    en           = 1'b0;
    lambda_valid = 1'b0;
    sync_clear   = 1'b0;
    out_ready    = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
